ae_seq: RTL and testbench

- Sequencer that drives the N-bit arithmetic element array and the downstream ripple adder.
- Accepts one ALU command per valid/ready handshake and drives the AE controls (ae_m, ae_s), the AE operand (ae_b), the adder A operand and carry-in each cycle.
- Captures adder results and returns them on a second valid/ready handshake.
- Runs ADD/SUB/CMP in one execute cycle and unsigned MUL as N shift-add iterations through the same array/adder.

---
 rtl/ae_seq_pkg.sv | 31 +++
 rtl/ae_seq_if.sv | 26 ++
 rtl/ae_seq_mulstep.sv | 43 ++++
 rtl/ae_seq.sv | 191 +++++++++++++++++++
 tb/tb_ae_seq.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ae_seq_pkg.sv
// rtl/ae_seq_pkg.sv - shared opcodes, AE selects, FSM states and counter sizing for ae_seq
package ae_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  localparam logic [1:0] AES_ZERO = 2'b00;
  localparam logic [1:0] AES_PASS = 2'b01;
  localparam logic [1:0] AES_INV  = 2'b10;
  localparam logic [1:0] AES_ONES = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Bits needed to count 0..n-1; never below 1 so the counter always exists.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ae_seq_if.sv
// rtl/ae_seq_if.sv - command and result handshake bundle for ae_seq
interface ae_seq_if #(parameter int N = 8);

  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_lo;
  logic [N-1:0] res_hi;
  logic         res_c;
  logic         res_z;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_lo, res_hi, res_c, res_z
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_lo, res_hi, res_c, res_z
  );

endinterface

// File: rtl/ae_seq_mulstep.sv
// rtl/ae_seq_mulstep.sv - one shift-add product step; AE_SEQ_SIGNED_MUL_EN selects two's complement fill
module ae_seq_mulstep
  import ae_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  input  logic [N-2:0] p_lo_upper,
`ifdef AE_SEQ_SIGNED_MUL_EN
  input  logic         p_hi_msb,
  input  logic [1:0]   ae_s,
  input  logic         ae_b_msb,
`endif
  output logic [N-1:0] p_hi_nxt,
  output logic [N-1:0] p_lo_nxt
);

  logic fill;

`ifdef AE_SEQ_SIGNED_MUL_EN
  logic aeout_msb;

  always_comb begin
    aeout_msb = 1'b0;
    case (ae_s)
      AES_ZERO: aeout_msb = 1'b0;
      AES_PASS: aeout_msb = ae_b_msb;
      AES_INV:  aeout_msb = ~ae_b_msb;
      default:  aeout_msb = 1'b1;
    endcase
  end

  // True sign of the N+1-bit sum of two sign-extended operands.
  assign fill = p_hi_msb ^ aeout_msb ^ add_cout;
`else
  assign fill = add_cout;
`endif

  assign p_hi_nxt = {fill, add_sum[N-1:1]};
  assign p_lo_nxt = {add_sum[0], p_lo_upper};

endmodule

// File: rtl/ae_seq.sv
// rtl/ae_seq.sv - ALU command sequencer driving the AE array and ripple adder
// Optional two's complement MUL when AE_SEQ_SIGNED_MUL_EN is defined.
module ae_seq
  import ae_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ae_seq_if.slave      bus,
  output logic         ae_m,
  output logic [1:0]   ae_s,
  output logic [N-1:0] ae_b,
  output logic [N-1:0] add_a,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] phi_q, phi_d, plo_q, plo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         ae_m_q, ae_m_d;
  logic [1:0]   ae_s_q, ae_s_d;
  logic [N-1:0] ae_b_q, ae_b_d, add_a_q, add_a_d;
  logic         add_cin_q, add_cin_d;
  logic         cmd_ready_q, cmd_ready_d, res_valid_q, res_valid_d;
  logic [N-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic         res_c_q, res_c_d, res_z_q, res_z_d;
  logic [N-1:0] phi_nxt, plo_nxt;

  ae_seq_mulstep #(.N(N)) u_mulstep (
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .p_lo_upper (plo_q[N-1:1]),
`ifdef AE_SEQ_SIGNED_MUL_EN
    .p_hi_msb   (phi_q[N-1]),
    .ae_s       (ae_s_q),
    .ae_b_msb   (ae_b_q[N-1]),
`endif
    .p_hi_nxt   (phi_nxt),
    .p_lo_nxt   (plo_nxt)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    phi_d       = phi_q;
    plo_d       = plo_q;
    cnt_d       = cnt_q;
    ae_m_d      = ae_m_q;
    ae_s_d      = ae_s_q;
    ae_b_d      = ae_b_q;
    add_a_d     = add_a_q;
    add_cin_d   = add_cin_q;
    res_valid_d = res_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    res_c_d     = res_c_q;
    res_z_d     = res_z_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          ae_b_d = bus.cmd_b;
          ae_m_d = 1'b1;
          cnt_d  = '0;
          if (bus.cmd_op == OP_MUL) begin
            phi_d     = '0;
            plo_d     = bus.cmd_a;
            add_a_d   = '0;
            ae_s_d    = bus.cmd_a[0] ? AES_PASS : AES_ZERO;
            add_cin_d = 1'b0;
            state_d   = S_MUL;
          end else begin
            add_a_d   = bus.cmd_a;
            ae_s_d    = (bus.cmd_op == OP_ADD) ? AES_PASS : AES_INV;
            add_cin_d = (bus.cmd_op != OP_ADD);
            state_d   = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_lo_d    = (op_q == OP_CMP) ? '0 : add_sum;
        res_hi_d    = '0;
        res_c_d     = add_cout;
        res_z_d     = (add_sum == '0);
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_MUL: begin
        phi_d = phi_nxt;
        plo_d = plo_nxt;
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          res_hi_d    = phi_nxt;
          res_lo_d    = plo_nxt;
          res_c_d     = 1'b0;
          res_z_d     = ({phi_nxt, plo_nxt} == '0);
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          add_a_d   = phi_nxt;
          ae_s_d    = plo_nxt[0] ? AES_PASS : AES_ZERO;
          add_cin_d = 1'b0;
`ifdef AE_SEQ_SIGNED_MUL_EN
          // The multiplier sign bit carries weight -2^(N-1): subtract on the last step.
          if (cnt_d == LAST && plo_nxt[0]) begin
            ae_s_d    = AES_INV;
            add_cin_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    // Array/adder controls fall back to their quiet values once no step is pending.
    if (state_d == S_DONE || state_d == S_IDLE) begin
      ae_m_d    = 1'b0;
      ae_s_d    = AES_ZERO;
      ae_b_d    = '0;
      add_a_d   = '0;
      add_cin_d = 1'b0;
    end

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      phi_q       <= '0;
      plo_q       <= '0;
      cnt_q       <= '0;
      ae_m_q      <= 1'b0;
      ae_s_q      <= AES_ZERO;
      ae_b_q      <= '0;
      add_a_q     <= '0;
      add_cin_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      res_c_q     <= 1'b0;
      res_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      phi_q       <= phi_d;
      plo_q       <= plo_d;
      cnt_q       <= cnt_d;
      ae_m_q      <= ae_m_d;
      ae_s_q      <= ae_s_d;
      ae_b_q      <= ae_b_d;
      add_a_q     <= add_a_d;
      add_cin_q   <= add_cin_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      res_c_q     <= res_c_d;
      res_z_q     <= res_z_d;
    end
  end

  assign ae_m          = ae_m_q;
  assign ae_s          = ae_s_q;
  assign ae_b          = ae_b_q;
  assign add_a         = add_a_q;
  assign add_cin       = add_cin_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_z     = res_z_q;

endmodule

// File: tb/tb_ae_seq.sv
// tb/tb_ae_seq.sv - directed vector bench for ae_seq with behavioural AE array and adder
module tb_ae_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ae_m;
  logic [1:0] ae_s;
  logic [7:0] ae_b, add_a, add_sum, ae_out;
  logic       add_cin, add_cout;
  int         errors = 0;
  int         checks = 0;

  ae_seq_if #(.N(8)) bus ();

  ae_seq #(.N(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ae_m     (ae_m),
    .ae_s     (ae_s),
    .ae_b     (ae_b),
    .add_a    (add_a),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (ae_s)
      2'b00:   ae_out = 8'h00;
      2'b01:   ae_out = ae_b;
      2'b10:   ae_out = ~ae_b;
      default: ae_out = 8'hFF;
    endcase
  end
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, ae_out} + {8'h00, add_cin};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] lo, output logic [7:0] hi,
                         output logic c, output logic z, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("drv_ae_m", {31'd0, ae_m}, 32'd1);
    chk("drv_ae_b", {24'd0, ae_b}, {24'd0, b});
    if (op == 2'b10) begin
      chk("drv_mul_add_a", {24'd0, add_a}, 32'd0);
      chk("drv_mul_ae_s", {30'd0, ae_s}, a[0] ? 32'd1 : 32'd0);
      chk("drv_mul_cin", {31'd0, add_cin}, 32'd0);
    end else begin
      chk("drv_add_a", {24'd0, add_a}, {24'd0, a});
      chk("drv_ae_s", {30'd0, ae_s}, (op == 2'b00) ? 32'd1 : 32'd2);
      chk("drv_cin", {31'd0, add_cin}, (op == 2'b00) ? 32'd0 : 32'd1);
    end
    lat = 1;
    while (!bus.res_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    lo = bus.res_lo;
    hi = bus.res_hi;
    c  = bus.res_c;
    z  = bus.res_z;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b, lo, hi;
    logic       c, chk_c, z;
    int         lat;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    logic [7:0] lo, hi;
    logic       c, z;
    int         lat;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo, hi;
    logic       c, z;
    int         lat;

    vecs[0] = '{2'b00, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 2};
    vecs[1] = '{2'b01, 8'h05, 8'h07, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{2'b11, 8'h3C, 8'h3C, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2};
    vecs[3] = '{2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2};
    vecs[4] = '{2'b11, 8'h10, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[5] = '{2'b10, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};
    vecs[6] = '{2'b10, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 9};
`ifdef AE_SEQ_SIGNED_MUL_EN
    vecs[7] = '{2'b10, 8'hFD, 8'h05, 8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0, 9};
    vecs[8] = '{2'b10, 8'h80, 8'h80, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 9};
`else
    vecs[7] = '{2'b10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9};
    vecs[8] = '{2'b10, 8'hFD, 8'h05, 8'hF1, 8'h04, 1'b0, 1'b0, 1'b0, 9};
`endif

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.res_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res", {14'd0, bus.res_lo, bus.res_hi, bus.res_c, bus.res_z}, 32'd0);
    chk("rst_drv", {12'd0, ae_m, ae_s, ae_b, add_a, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi, c, z, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_lo", i), {24'd0, lo}, {24'd0, vecs[i].lo});
      chk($sformatf("v%0d_hi", i), {24'd0, hi}, {24'd0, vecs[i].hi});
      chk($sformatf("v%0d_z", i), {31'd0, z}, {31'd0, vecs[i].z});
      if (vecs[i].chk_c) chk($sformatf("v%0d_c", i), {31'd0, c}, {31'd0, vecs[i].c});
    end

    // Backpressure: result held, new commands ignored until after the handshake
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = 8'h12;
    bus.cmd_b     = 8'h34;
    @(posedge clk);
    #1;
    bus.cmd_op = 2'b01;
    bus.cmd_a  = 8'h99;
    bus.cmd_b  = 8'h11;
    @(posedge clk);
    #1;
    chk("bp_first_valid", {31'd0, bus.res_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_%0d", k), {31'd0, bus.res_valid}, 32'd1);
      chk($sformatf("bp_lo_%0d", k), {24'd0, bus.res_lo}, 32'h46);
      chk($sformatf("bp_cmd_ready_%0d", k), {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = 8'h01;
    bus.cmd_b     = 8'h02;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("bp_after_hs_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("bp_after_hs_valid", {31'd0, bus.res_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("bp_next_add_a", {24'd0, add_a}, 32'h01);
    @(posedge clk);
    #1;
    chk("bp_next_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("bp_next_lo", {24'd0, bus.res_lo}, 32'h03);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_a     = 8'hFF;
    bus.cmd_b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("mrst_drv", {12'd0, ae_m, ae_s, ae_b, add_a, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mrst_no_result", {31'd0, bus.res_valid}, 32'd0);
    end
    run_cmd(2'b00, 8'h01, 8'h01, lo, hi, c, z, lat);
    chk("mrst_add_lo", {24'd0, lo}, 32'h02);
    chk("mrst_add_lat", lat, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
